// File: rtl/serial_addsub_unit_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract engine.
// The requester drives start/mode/operands; the engine returns busy/done plus result flags.
// No flow control beyond start/busy: a start seen while busy is simply dropped.
interface serial_addsub_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] OPA;
    logic [WIDTH-1:0] OPB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryOut;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start, mode, OPA, OPB,
        input  busy, done, result, carryOut, borrow, overflow, zero
    );

    modport slave (
        input  start, mode, OPA, OPB,
        output busy, done, result, carryOut, borrow, overflow, zero
    );
endinterface

// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract: one full-adder evaluation per clock, LSB first.
// Latency: done pulses in the cycle after edge E0+WIDTH (E0 = start capture edge).
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
module serial_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_addsub_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] pr;       // partial result; new bit enters at the top
    logic             carry;    // running carry into the bit being processed
    logic             mode_q;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;

    // Full-adder cell on the current LSBs, and the partial result including this bit
    always_comb begin
        fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
        fa_c     = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        res_next = {fa_s, pr};
    end

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            pr           <= '0;
            carry        <= 1'b0;
            mode_q       <= 1'b0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.carryOut <= 1'b0;
            bus.borrow   <= 1'b0;
            bus.overflow <= 1'b0;
            bus.zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr     <= bus.OPA;
                        // Subtract is A + ~B + 1; the +1 comes in as the initial carry
                        b_sr     <= bus.mode ? ~bus.OPB : bus.OPB;
                        carry    <= bus.mode;
                        mode_q   <= bus.mode;
                        cnt      <= '0;
                        pr       <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    pr    <= res_next[WIDTH-1:1];
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Last bit: carry still holds the carry into the MSB
                        bus.result   <= res_next;
                        bus.carryOut <= fa_c;
                        bus.borrow   <= mode_q & ~fa_c;
                        bus.overflow <= carry ^ fa_c;
                        bus.zero     <= (res_next == '0);
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit at WIDTH = 8: directed table, corner sequences, random ops.
// Expected values come from plain integer arithmetic on the operands.
// Watchdog bounds the whole run.
module tb_serial_addsub_unit;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    serial_addsub_unit_if #(.WIDTH(W)) bus ();

    serial_addsub_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       co;
        logic       bo;
        logic       ov;
        logic       z;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: integer arithmetic, signed range test for overflow
    task automatic model(input logic m, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic co, output logic bo,
                         output logic ov, output logic z);
        int sa, sb, sr, ur;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = m ? sa - sb : sa + sb;
        ur = m ? int'(a) - int'(b) : int'(a) + int'(b);
        r  = ur[7:0];
        co = m ? (a >= b) : (ur > 255);
        bo = m & ~co;
        ov = (sr > 127) || (sr < -128);
        z  = (r == 8'h00);
    endtask

    task automatic check_outs(input logic [7:0] r, input logic co, input logic bo,
                              input logic ov, input logic z);
        chk("result",   32'(bus.result),   32'(r));
        chk("carryOut", 32'(bus.carryOut), 32'(co));
        chk("borrow",   32'(bus.borrow),   32'(bo));
        chk("overflow", 32'(bus.overflow), 32'(ov));
        chk("zero",     32'(bus.zero),     32'(z));
    endtask

    // Launch one operation, check busy/latency/done shape; returns after DONE->IDLE
    task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b);
        int lat;
        @(negedge clk);
        bus.mode  = m;
        bus.OPA   = a;
        bus.OPB   = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done && lat < W + 6);
        chk("done_latency", 32'(lat), 32'(W));
        @(posedge clk);
        #1;
        chk("done_drop", 32'(bus.done), 32'd0);
        chk("busy_drop", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       co, bo, ov, z;
        int         done_cnt;
        int         t1, t2;

        n_vec = 0;
        n_err = 0;

        tbl[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 8'h2A, 8'h2A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};

        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.OPA   = '0;
        bus.OPB   = '0;
        rst       = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        check_outs(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].m, tbl[i].a, tbl[i].b);
            check_outs(tbl[i].r, tbl[i].co, tbl[i].bo, tbl[i].ov, tbl[i].z);
        end

        // Start while busy is dropped; operand changes mid-RUN have no effect
        @(negedge clk);
        bus.mode  = 1'b0;
        bus.OPA   = 8'h10;
        bus.OPB   = 8'h10;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_cnt  = 0;
        t1        = 0;
        for (int i = 1; i <= W + 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                t1 = i;
            end
            if (i == 2) begin
                bus.start = 1'b1;
                bus.mode  = 1'b1;
                bus.OPA   = 8'h01;
                bus.OPB   = 8'h01;
            end
            if (i == 3) bus.start = 1'b0;
            if (i == 5) begin
                bus.OPA = 8'hFF;
                bus.OPB = 8'hAA;
            end
        end
        chk("ignored_start_done_count", 32'(done_cnt), 32'd1);
        chk("ignored_start_latency", 32'(t1), 32'(W));
        chk("ignored_start_busy_idle", 32'(bus.busy), 32'd0);
        check_outs(8'h20, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset three cycles into RUN
        @(negedge clk);
        bus.mode  = 1'b0;
        bus.OPA   = 8'h33;
        bus.OPB   = 8'h44;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
        chk("midrun_rst_done", 32'(bus.done), 32'd0);
        check_outs(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        chk("midrun_rst_no_done", 32'(done_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b1, 8'h09, 8'h04);
        check_outs(8'h05, 1'b1, 1'b0, 1'b0, 1'b0);

        // start held high: one operation every W+2 cycles
        @(negedge clk);
        bus.mode  = 1'b0;
        bus.OPA   = 8'h01;
        bus.OPB   = 8'h02;
        bus.start = 1'b1;
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        bus.start = 1'b0;
        chk("b2b_second_done_seen", 32'(t2 >= 0), 32'd1);
        chk("b2b_period", 32'(t2 - t1), 32'(W + 2));
        repeat (W + 4) @(posedge clk);
        #1;
        chk("b2b_idle", 32'(bus.busy), 32'd0);
        check_outs(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic       m;
            logic [7:0] a, b;
            m = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            model(m, a, b, r, co, bo, ov, z);
            run_op(m, a, b);
            check_outs(r, co, bo, ov, z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
